ahb_sram_ctrl: RTL



---
 rtl/ahb_lite_pkg.sv | 36 +++
 rtl/ahb_sram_ctrl_if.sv | 26 ++
 rtl/ahb_sram_ctrl_sram_bytewrite.sv | 29 ++
 rtl/ahb_sram_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite definitions for the SRAM slave.
// Contents: HTRANS/HSIZE/HRESP encodings, the controller state type and the
// byte-lane mask helper used in the address phase.
package ahb_lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } state_t;

   // Byte lanes touched by an aligned transfer; callers reject misaligned ones.
   function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offs);
      logic [3:0] m;
      case (size)
         HSIZE_BYTE: m = 4'b0001 << offs;
         HSIZE_HALF: m = 4'b0011 << {offs[1], 1'b0};
         default:    m = 4'b1111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ahb_sram_ctrl_if.sv
// AHB-Lite slave-side bus bundle for ahb_sram_ctrl.
// slave modport: address/control/write data and WPROT in; HREADYOUT/HRESP/HRDATA out.
// master modport: the mirror image, for a bus master or testbench driver.
interface ahb_sram_ctrl_if;
   logic        HSEL;
   logic        HREADY;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        WPROT;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;

   modport slave (
      input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, WPROT,
      output HREADYOUT, HRESP, HRDATA
   );

   modport master (
      output HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, WPROT,
      input  HREADYOUT, HRESP, HRDATA
   );
endinterface

// File: rtl/ahb_sram_ctrl_sram_bytewrite.sv
// 32-bit wide RAM with per-byte write enables and a registered read port.
// Kept free of bus logic so block-RAM inference sees a plain template.
// Ports: clk; we[3:0]/waddr/wdata write port; re/raddr/rdata synchronous read port.
// No reset: contents and read register are undefined until written.
module sram_bytewrite #(
   parameter int    AW        = 13,
   parameter string INIT_FILE = ""
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [0:(1<<AW)-1];

   // Read returns the pre-write contents on an address collision; the
   // controller merges freshly written lanes itself.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite SRAM slave with configurable wait states, byte-lane writes,
// same-word write-to-read forwarding and two-cycle ERROR responses for
// misaligned transfers or writes into the protected low region.
// Ports: HCLK, HRESETn (async, active low), bus (ahb_sram_ctrl_if.slave).
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | HREADYOUT=1; no transfer, or final data cycle of an OK one
// ST_WAIT | HREADYOUT=0; inserted wait states, down-counter running
// ST_ERR1 | HREADYOUT=0, HRESP=1; first ERROR cycle
// ST_ERR2 | HREADYOUT=1, HRESP=1; second ERROR cycle, may accept next
module ahb_sram_ctrl
   import ahb_lite_pkg::*;
#(
   parameter int    MEMWIDTH    = 15,
   parameter int    WAIT_STATES = 0,
   parameter int    PROT_WORDS  = 2048,
   parameter string INIT_FILE   = "code.hex"
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   ahb_sram_ctrl_if.slave bus
);

   localparam int          AW       = MEMWIDTH - 2;
   localparam logic [3:0]  WS       = 4'(WAIT_STATES);
   localparam logic [31:0] PROT_LIM = 32'(PROT_WORDS);

   state_t        state, state_nxt;
   logic          hready_int, hresp_int;
   logic [3:0]    wait_cnt;

   logic [AW-1:0] ap_addr;
   logic          ap_misaligned, ap_prot, ap_err, accept, commit;

   logic          dp_valid, dp_write;
   logic [AW-1:0] dp_addr;
   logic [3:0]    dp_mask;

   logic          rd_ok;
   logic [3:0]    fwd_mask;
   logic [31:0]   fwd_data, ram_rdata;

   logic          unused_bits;
   assign unused_bits = ^{bus.HADDR[31:MEMWIDTH], bus.HTRANS[0]};

   assign ap_addr       = bus.HADDR[MEMWIDTH-1:2];
   assign ap_misaligned = (bus.HSIZE > HSIZE_WORD)
                        | ((bus.HSIZE == HSIZE_HALF) & bus.HADDR[0])
                        | ((bus.HSIZE == HSIZE_WORD) & (bus.HADDR[1:0] != 2'b00));
   assign ap_prot       = bus.HWRITE & bus.WPROT & (32'(ap_addr) < PROT_LIM);
   assign ap_err        = ap_misaligned | ap_prot;
   assign accept        = bus.HSEL & bus.HREADY & bus.HTRANS[1] & hready_int;

   // dp_valid is only ever set for OK transfers and is held through WAIT,
   // so being back in IDLE with it set marks the final data cycle.
   assign commit = dp_valid & dp_write & (state == ST_IDLE);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_ERR2: begin
            if (!accept)     state_nxt = ST_IDLE;
            else if (ap_err) state_nxt = ST_ERR1;
            else if (WS != 4'd0) state_nxt = ST_WAIT;
            else             state_nxt = ST_IDLE;
         end
         ST_WAIT: if (wait_cnt == 4'd1) state_nxt = ST_IDLE;
         ST_ERR1: state_nxt = ST_ERR2;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      hready_int = 1'b1;
      hresp_int  = HRESP_OKAY;
      case (state)
         ST_WAIT: hready_int = 1'b0;
         ST_ERR1: begin
            hready_int = 1'b0;
            hresp_int  = HRESP_ERROR;
         end
         ST_ERR2: hresp_int = HRESP_ERROR;
         default: ;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)                wait_cnt <= 4'd0;
      else if (state == ST_WAIT)   wait_cnt <= wait_cnt - 4'd1;
      else if (accept && !ap_err)  wait_cnt <= WS;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_addr  <= '0;
         dp_mask  <= 4'b0;
      end else if (hready_int) begin
         dp_valid <= accept & ~ap_err;
         if (accept) begin
            dp_write <= bus.HWRITE;
            dp_addr  <= ap_addr;
            dp_mask  <= lane_mask(bus.HSIZE, bus.HADDR[1:0]);
         end
      end
   end

   // Read-side state only moves on reads, so HRDATA holds across writes and idle.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         rd_ok    <= 1'b0;
         fwd_mask <= 4'b0;
         fwd_data <= '0;
      end else if (accept && !bus.HWRITE) begin
         rd_ok    <= ~ap_err;
         fwd_mask <= (commit && (dp_addr == ap_addr)) ? dp_mask : 4'b0;
         fwd_data <= bus.HWDATA;
      end
   end

   sram_bytewrite #(
      .AW        (AW),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clk   (HCLK),
      .we    (commit ? dp_mask : 4'b0),
      .waddr (dp_addr),
      .wdata (bus.HWDATA),
      .re    (accept & ~bus.HWRITE & ~ap_err),
      .raddr (ap_addr),
      .rdata (ram_rdata)
   );

   always_comb begin
      bus.HRDATA = '0;
      if (rd_ok) begin
         for (int i = 0; i < 4; i++) begin
            bus.HRDATA[8*i +: 8] = fwd_mask[i] ? fwd_data[8*i +: 8] : ram_rdata[8*i +: 8];
         end
      end
   end

   assign bus.HREADYOUT = hready_int;
   assign bus.HRESP     = hresp_int;

endmodule
